mdu_sequencer: RTL and testbench

Multi-cycle sequencer for the M-extension unit in the execute stage. Accepts one MUL/DIV/REM operation at a time from EX, drives the shared registered multiplier cores for MUL* ops, runs an internal 32-iteration restoring divider for DIV*/REM* ops, and stalls the pipeline until the result is ready. It returns a single 32-bit result to the EX result mux.

---
 rtl/mdu_sequencer.sv | 152 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// M-extension sequencer: launches MUL ops on the external registered multiplier
// cores and runs a 32-step restoring divider for DIV/REM, stalling EX until done.
module mdu_sequencer #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [4:0]  mul_ctrl,
  input  logic [31:0] mul_result
);

  localparam logic [4:0] OP_MUL   = 5'h0a;
  localparam logic [4:0] OP_MULHU = 5'h0d;
  localparam logic [4:0] OP_DIV   = 5'h0e;
  localparam logic [4:0] OP_REM   = 5'h10;
  localparam logic [4:0] OP_REMU  = 5'h11;

  localparam int CNT_W = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(31);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [32:0]       r_rem;
  logic [31:0]       r_quo;
  logic [31:0]       r_div;
  logic              r_neg_q, r_neg_r, r_is_rem;

  logic              w_valid, w_is_mul, w_signed, w_is_rem, w_div0, w_ovf, w_launch;
  logic [31:0]       w_abs_a, w_abs_b;
  logic [32:0]       w_shift, w_diff, w_r_next;
  logic [31:0]       w_q_next, w_q_fix, w_r_fix;

  assign w_valid  = (op >= OP_MUL) && (op <= OP_REMU);
  assign w_is_mul = (op <= OP_MULHU);
  assign w_signed = (op == OP_DIV) || (op == OP_REM);
  assign w_is_rem = (op == OP_REM) || (op == OP_REMU);
  assign w_div0   = (src_b == '0);
  assign w_ovf    = w_signed && (src_a == 32'h8000_0000) && (src_b == '1);
  assign w_launch = start && w_valid && !flush;

  assign w_abs_a  = (w_signed && src_a[31]) ? -src_a : src_a;
  assign w_abs_b  = (w_signed && src_b[31]) ? -src_b : src_b;

  // The dividend is shifted out of r_quo MSB-first while quotient bits enter at the LSB.
  assign w_shift  = {r_rem[31:0], r_quo[31]};
  assign w_diff   = w_shift - {1'b0, r_div};
  assign w_q_next = {r_quo[30:0], ~w_diff[32]};
  assign w_r_next = w_diff[32] ? w_shift : w_diff;
  assign w_q_fix  = r_neg_q ? -w_q_next : w_q_next;
  assign w_r_fix  = r_neg_r ? -w_r_next[31:0] : w_r_next[31:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          if (w_is_mul)             w_next = MUL_WAIT;
          else if (w_div0 || w_ovf) w_next = DONE;
          else                      w_next = DIV_RUN;
        end
      end
      MUL_WAIT, DIV_RUN: begin
        if (flush)             w_next = IDLE;
        else if (r_cnt == '0)  w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state == MUL_WAIT) || (r_state == DIV_RUN);
    done  = (r_state == DONE);
    stall = reset_n && (((r_state == IDLE) && start && w_valid) || busy);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      result   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_ctrl <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            if (w_is_mul) begin
              mul_a    <= src_a;
              mul_b    <= src_b;
              mul_ctrl <= op;
              r_cnt    <= MUL_CNT_INIT;
            end else if (w_div0) begin
              result <= w_is_rem ? src_a : '1;
            end else if (w_ovf) begin
              result <= w_is_rem ? '0 : 32'h8000_0000;
            end else begin
              r_rem    <= '0;
              r_quo    <= w_abs_a;
              r_div    <= w_abs_b;
              r_neg_q  <= w_signed && (src_a[31] ^ src_b[31]);
              r_neg_r  <= w_signed && src_a[31];
              r_is_rem <= w_is_rem;
              r_cnt    <= DIV_CNT_INIT;
            end
          end
        end
        MUL_WAIT: begin
          if (!flush) begin
            if (r_cnt == '0) result <= mul_result;
            else             r_cnt  <= r_cnt - 1'b1;
          end
        end
        DIV_RUN: begin
          if (!flush) begin
            r_rem <= w_r_next;
            r_quo <= w_q_next;
            if (r_cnt == '0) result <= r_is_rem ? w_r_fix : w_q_fix;
            else             r_cnt  <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a pipelined behavioural multiplier core.
module tb_mdu_sequencer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall, busy, done;
  logic [31:0] result, mul_a, mul_b, mul_result;
  logic [4:0]  mul_ctrl;

  int checks = 0;
  int failures = 0;

  mdu_sequencer #(.MUL_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ctrl(mul_ctrl), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mul_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (c == 5'h0b || c == 5'h0c) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (c == 5'h0b) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (c == 5'h0a) ? p[31:0] : p[63:32];
  endfunction

  // Operands appear in T1; the product reaches the output in T0+LAT.
  logic [31:0] mul_pipe [LAT-1];
  always_ff @(posedge clk) begin
    mul_pipe[0] <= mul_model(mul_ctrl, mul_a, mul_b);
    for (int i = 1; i < LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[LAT-2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Leaves start high on return, in the done cycle.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   k;
    logic stall_ok;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 check({tag, "_stall_t0"}, 32'(stall), 32'd1);
    k = 0;
    stall_ok = 1'b1;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) break;
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(k), 32'(lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_stall_window"}, 32'(stall_ok), 32'd1);
  endtask

  task automatic flush_div(input string tag, input int fc, input logic [31:0] prior);
    logic done_seen;
    @(negedge clk);
    start = 1'b1; op = 5'h0f; src_a = 32'd100; src_b = 32'd7;
    repeat (fc) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, prior);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    check({tag, "_no_done"}, 32'(done_seen), 32'd0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    start = 1'b1; op = 5'h0a; src_a = 32'd7; src_b = 32'd3;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_mul_ctrl", 32'(mul_ctrl), 32'd0);
    @(negedge clk); @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;

    @(negedge clk);
    start = 1'b1; op = 5'h09;
    #1 check("inv09_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("inv09_busy", 32'(busy), 32'd0);
    op = 5'h12;
    #1 check("inv12_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("inv12_busy", 32'(busy), 32'd0);
    check("inv12_done", 32'(done), 32'd0);
    start = 1'b0;

    run_op("mul", 5'h0a, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT + 1);
    start = 1'b0;
    check("mul_a_held", mul_a, 32'd7);
    check("mul_b_held", mul_b, 32'hFFFF_FFFD);
    check("mul_ctrl_held", 32'(mul_ctrl), 32'h0a);
    run_op("mulh", 5'h0b, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT + 1);
    start = 1'b0;
    run_op("mulhu", 5'h0d, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT + 1);
    start = 1'b0;
    run_op("mulhsu", 5'h0c, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT + 1);
    start = 1'b0;

    run_op("div", 5'h0e, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    start = 1'b0;
    run_op("rem", 5'h10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    start = 1'b0;
    run_op("divu", 5'h0f, 32'd100, 32'd7, 32'd14, 33);
    start = 1'b0;
    run_op("remu", 5'h11, 32'd100, 32'd7, 32'd2, 33);
    start = 1'b0;
    run_op("div_ovf", 5'h0e, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    start = 1'b0;
    run_op("rem_ovf", 5'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    start = 1'b0;
    run_op("div_by0", 5'h0e, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    start = 1'b0;
    run_op("remu_by0", 5'h11, 32'd5, 32'd0, 32'd5, 1);
    start = 1'b0;

    flush_div("flush_t10", 10, 32'd5);
    flush_div("flush_last", 32, 32'd5);

    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 5'h0a; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 32'(busy), 32'd0);
    check("flush_idle_mul_a", mul_a, 32'hFFFF_FFFF);
    @(negedge clk);
    check("flush_idle_done", 32'(done), 32'd0);

    @(negedge clk);
    start = 1'b1; op = 5'h0a; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk); @(negedge clk);
    check("rstmid_pre_mul_a", mul_a, 32'd9);
    reset_n = 1'b0;
    #1;
    check("rstmid_result", result, 32'd0);
    check("rstmid_mul_a", mul_a, 32'd0);
    check("rstmid_mul_b", mul_b, 32'd0);
    check("rstmid_mul_ctrl", 32'(mul_ctrl), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    run_op("b2b_mul", 5'h0a, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT + 1);
    run_op("b2b_div", 5'h0e, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    start = 1'b0;
    @(negedge clk);
    check("b2b_after_done", 32'(done), 32'd0);
    check("b2b_after_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
